sram_uploader: RTL and testbench
================================

Name: sram_uploader

Overview:
- Upload path: the core returns SRAM contents to the host through the data_io upload channel. This is the reverse of the download path that writes host bytes into SRAM.
- Sits between data_io (upload side), the 8-bit external SRAM and the video fetcher, and time-multiplexes the SRAM between the two readers.
- Video keeps its fixed access slot. Upload reads use only the remaining cycles.

Parameters:
AW, 21, SRAM address width.
BASE, 0, SRAM address of upload byte 0.
SIZE, 32768, number of bytes backed by SRAM; bytes at or beyond SIZE read as 8'hFF with no SRAM access.
WAIT, 1, cycles the SRAM address must be held before data is sampled (1..7).

Ports:
clock  in  1  system clock (28 MHz domain).
reset  in  1  synchronous, active-high reset.
ce  in  1  video slot strobe; when high, the SRAM address is vidA.
vidA  in  AW  video read address.
vidQ  out  8  video data, registered.
ioctlU  in  1  upload active (data_io ioctl_upload).
ioctlR  in  1  one-cycle pulse: host consumed the current byte.
ioctlA  in  25  current upload byte index from data_io.
ioctlD  out  8  byte presented to the host.
ioctlV  out  1  ioctlD is valid for the current index.
sramA  out  AW  SRAM address.
sramOe  out  1  SRAM output enable, active low.
sramQ  in  8  SRAM read data.
csum  out  8  running checksum (see Optional Feature).

Behaviour:
- Reset values: vidQ=0, ioctlD=8'hFF, ioctlV=0, sramA=0, sramOe=0, csum=0. FSM goes to IDLE and the index register goes to 0.
- Video slot:
  - In a cycle with ce=1, sramA=vidA (combinational mux).
  - vidQ<=sramQ is captured WAIT cycles after the slot begins, using a per-slot delay pipeline.
  - Video always wins. An upload access in progress during a ce cycle loses that cycle.
- Upload FSM states: IDLE, SETUP, SAMPLE, VALID.
- IDLE:
  - ioctlV=0.
  - On the rising edge of ioctlU: idx<=ioctlA[AW-1:0], then go to SETUP.
- SETUP:
  - If idx>=SIZE: ioctlD<=8'hFF, go straight to VALID (next cycle).
  - Otherwise, in non-ce cycles, drive sramA=BASE+idx (AW-bit sum, wraps modulo 2^AW) and count up.
  - Any ce=1 cycle clears the counter.
  - When the counter reaches WAIT, go to SAMPLE.
- SAMPLE:
  - If ce=0: ioctlD<=sramQ, go to VALID.
  - If ce=1: return to SETUP with the counter cleared.
- VALID:
  - ioctlV=1.
  - On ioctlR: ioctlV<=0, idx<=idx+1, go to SETUP (prefetch of the next byte).
  - ioctlR while not in VALID is ignored. The host may not consume an invalid byte; the bench flags it as an error.
- Latency, with no video interference: ioctlU rise to ioctlV=1 is WAIT+2 cycles; ioctlR to the next ioctlV=1 is WAIT+2 cycles.
- ioctlU falling in any state: go to IDLE and ioctlV<=0 the next cycle. ioctlD holds its last value.
- ioctlU re-asserted: restarts from the current ioctlA.
- Simultaneous ioctlU fall and ioctlR: the fall wins and idx does not advance.
- idx wraps at 2^AW. The SIZE check uses the full idx.
- Reset mid-upload: immediately IDLE. A later upload requires a fresh ioctlU rising edge.
- sramOe is held at 0; the block never writes the SRAM.

Optional Feature:
- Macro: SRAM_UPLOADER_CSUM_EN.
- Defined: on each VALID->SETUP transition, csum<=csum+ioctlD (mod 256). csum clears on the ioctlU rising edge and on reset.
- Not defined: csum is tied to 0 and no adder is synthesised.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, SETUP, SAMPLE, VALID).
  - Constant FF_FILL=8'hFF.
  - Width of the WAIT counter (3 bits).
- Sub-module sram_slot_mux: ce-driven address mux plus the WAIT-deep video capture pipeline. It returns a "free cycle" flag to the FSM.

Test Plan:
- WAIT=1, SRAM model preloaded, addr 0=8'h3C; ioctlU rises with ioctlA=0, ce=0 always -> ioctlV=1 at cycle 3, ioctlD=8'h3C.
- ce pulses 1 of every 4 cycles, addresses 0..15 = 8'h10..8'h1F, host pulses ioctlR on each valid byte -> 16 bytes 8'h10..8'h1F delivered in order; vidQ matches the model at every slot.
- SIZE=4, upload indices 3,4,5 -> ioctlD = model[3], 8'hFF, 8'hFF; sramA never equals BASE+4 or BASE+5.
- ioctlU falls in SETUP; reset asserted in VALID -> ioctlV=0 next cycle, FSM IDLE; re-raise ioctlU with ioctlA=7 -> byte 7 delivered.
- ioctlR and ioctlU fall in the same cycle -> no index advance; csum unchanged.
- SRAM_UPLOADER_CSUM_EN defined, bytes 8'hF0, 8'h20, 8'h01 consumed -> csum=8'h11; with the macro undefined -> csum=0.

Source files
------------

// File: rtl/sram_uploader_pkg.sv
// sram_uploader_pkg: upload FSM encoding and shared constants for the
// SRAM upload path.
package sram_uploader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SAMPLE,
        VALID
    } upl_state_t;

    localparam logic [7:0] FF_FILL = 8'hFF;

    // Width of the address-hold counter (WAIT is limited to 1..7)
    localparam int unsigned CNT_W = 3;

    // True when an upload index is outside the SRAM-backed window
    function automatic logic beyond_size(input logic [31:0] index, input int unsigned size);
        return index >= size;
    endfunction

endpackage

// File: rtl/sram_uploader_if.sv
// sram_uploader_if: video, data_io upload and SRAM signals of the uploader.
// master = environment side, slave = sram_uploader.
interface sram_uploader_if #(
    parameter int unsigned AW = 21
);
    logic          ce;
    logic [AW-1:0] vidA;
    logic [7:0]    vidQ;
    logic          ioctlU;
    logic          ioctlR;
    logic [24:0]   ioctlA;
    logic [7:0]    ioctlD;
    logic          ioctlV;
    logic [AW-1:0] sramA;
    logic          sramOe;
    logic [7:0]    sramQ;
    logic [7:0]    csum;

    modport master (
        output ce, vidA, ioctlU, ioctlR, ioctlA, sramQ,
        input  vidQ, ioctlD, ioctlV, sramA, sramOe, csum
    );

    modport slave (
        input  ce, vidA, ioctlU, ioctlR, ioctlA, sramQ,
        output vidQ, ioctlD, ioctlV, sramA, sramOe, csum
    );
endinterface

// File: rtl/sram_uploader_slot_mux.sv
// sram_slot_mux: gives the SRAM address to video during ce slots and to the
// upload path otherwise; captures video data WAIT cycles after each slot.
module sram_slot_mux
    import sram_uploader_pkg::*;
#(
    parameter int unsigned AW   = 21,
    parameter int unsigned WAIT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic [AW-1:0] vid_a,
    input  logic [AW-1:0] upl_a,
    input  logic [7:0]    sram_q,
    output logic [AW-1:0] sram_a,
    output logic [7:0]    vid_q,
    output logic          free
);

    logic [WAIT-1:0] slot_pipe;

    // Video always owns the SRAM during its slot; other cycles belong to upload
    always_comb begin
        sram_a = ce ? vid_a : upl_a;
        free   = ~ce;
    end

    // Delay each slot marker WAIT cycles, then latch the video byte
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_pipe <= '0;
            vid_q     <= '0;
        end else begin
            slot_pipe <= (slot_pipe << 1) | WAIT'(ce);
            if (slot_pipe[WAIT-1]) begin
                vid_q <= sram_q;
            end
        end
    end

endmodule

// File: rtl/sram_uploader.sv
// sram_uploader: returns SRAM contents to the host over the data_io upload
// channel, reading only in cycles not taken by the video slot.
// Optional: define SRAM_UPLOADER_CSUM_EN for the running checksum on csum.
module sram_uploader
    import sram_uploader_pkg::*;
#(
    parameter int unsigned AW   = 21,
    parameter int unsigned BASE = 0,
    parameter int unsigned SIZE = 32768,
    parameter int unsigned WAIT = 1
) (
    input logic            clock,
    input logic            reset,
    sram_uploader_if.slave bus
);

    localparam logic [AW-1:0]    BASE_A   = AW'(BASE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT - 1);

    upl_state_t       state;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    upl_a;
    logic [CNT_W-1:0] cnt;
    logic             u_q;
    logic             free;
    logic             past_end;
    logic             start;
    logic             consume;
    logic [7:0]       io_d;
    logic             io_v;
    logic             unused_ok;

    sram_slot_mux #(
        .AW   (AW),
        .WAIT (WAIT)
    ) u_slot_mux (
        .clock  (clock),
        .reset  (reset),
        .ce     (bus.ce),
        .vid_a  (bus.vidA),
        .upl_a  (upl_a),
        .sram_q (bus.sramQ),
        .sram_a (bus.sramA),
        .vid_q  (bus.vidQ),
        .free   (free)
    );

    // Upload start/consume events and the address the upload path wants
    always_comb begin
        past_end = beyond_size(32'(idx), SIZE);
        start    = bus.ioctlU & ~u_q & (state == IDLE);
        consume  = bus.ioctlU & bus.ioctlR & (state == VALID);
        upl_a    = '0;
        if ((state == SETUP && !past_end) || state == SAMPLE) begin
            upl_a = BASE_A + idx;
        end
    end

    // Upload FSM: hold the address WAIT free cycles, sample, present to host
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            u_q   <= 1'b1;  // a fresh ioctlU rise is needed after reset
            io_d  <= FF_FILL;
            io_v  <= 1'b0;
        end else begin
            u_q <= bus.ioctlU;
            if (!bus.ioctlU) begin
                state <= IDLE;
                io_v  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        io_v <= 1'b0;
                        if (start) begin
                            idx   <= bus.ioctlA[AW-1:0];
                            cnt   <= '0;
                            state <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (past_end) begin
                            io_d  <= FF_FILL;
                            io_v  <= 1'b1;
                            state <= VALID;
                        end else if (!free) begin
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= SAMPLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SAMPLE: begin
                        if (free) begin
                            io_d  <= bus.sramQ;
                            io_v  <= 1'b1;
                            state <= VALID;
                        end else begin
                            cnt   <= '0;
                            state <= SETUP;
                        end
                    end
                    VALID: begin
                        if (consume) begin
                            io_v  <= 1'b0;
                            idx   <= idx + 1'b1;
                            cnt   <= '0;
                            state <= SETUP;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SRAM_UPLOADER_CSUM_EN
    logic [7:0] sum;

    // Running sum of consumed bytes, restarted with each upload
    always_ff @(posedge clock) begin
        if (reset || start) begin
            sum <= '0;
        end else if (consume) begin
            sum <= sum + io_d;
        end
    end

    assign bus.csum = sum;
`else
    assign bus.csum = '0;
`endif

    assign bus.ioctlD = io_d;
    assign bus.ioctlV = io_v;
    assign bus.sramOe = 1'b0;
    assign unused_ok  = &{1'b0, bus.ioctlA};

endmodule

// File: tb/tb_sram_uploader.sv
// tb_sram_uploader: directed/randomized bench for sram_uploader with an
// SRAM model of WAIT cycles read latency and a host/video reference model.
module tb_sram_uploader;

    localparam int unsigned AW   = 21;
    localparam int unsigned BASE = 0;
    localparam int unsigned SIZE = 16;
    localparam int unsigned WAIT = 1;

`ifdef SRAM_UPLOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic ce_mode  = 1'b0;
    logic watch_oor = 1'b0;
    logic bad_hit  = 1'b0;

    logic [7:0]    mem  [256];
    logic [AW-1:0] hist [WAIT];

    typedef struct {
        int         due;
        logic [7:0] val;
    } vid_exp_t;
    vid_exp_t vq[$];

    sram_uploader_if #(.AW(AW)) bus ();

    sram_uploader #(
        .AW   (AW),
        .BASE (BASE),
        .SIZE (SIZE),
        .WAIT (WAIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // SRAM model: data for an address appears WAIT cycles after it is driven
    always @(posedge clock) begin
        hist[0] <= bus.sramA;
        for (int i = 1; i < WAIT; i++) hist[i] <= hist[i-1];
    end
    assign bus.sramQ = mem[hist[WAIT-1][7:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte the host should see for an upload index
    function automatic logic [7:0] exp_byte(input longint index);
        longint span = longint'(1) << AW;
        longint i    = index % span;
        longint addr;
        if (i >= longint'(SIZE)) return 8'hFF;
        addr = (longint'(BASE) + i) % span;
        return mem[int'(addr % 256)];
    endfunction

    // Video slot driver: one slot every 4 cycles while enabled
    initial begin : video_driver
        bus.ce   = 1'b0;
        bus.vidA = '0;
        forever begin
            @(posedge clock);
            #1;
            if (ce_mode && (cyc % 4 == 0)) begin
                bus.ce   = 1'b1;
                bus.vidA = AW'($urandom);
                vq.push_back('{due: cyc + int'(WAIT) + 1, val: mem[bus.vidA[7:0]]});
            end else begin
                bus.ce = 1'b0;
            end
        end
    end

    // Video data, video address and out-of-window access monitor
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (vq.size() > 0 && vq[0].due == cyc) begin
                check("vidQ", 32'(bus.vidQ), 32'(vq[0].val));
                void'(vq.pop_front());
            end
            if (bus.ce) begin
                check("sramA_video", 32'(bus.sramA), 32'(bus.vidA));
            end else if (watch_oor && (bus.sramA == AW'(BASE + SIZE) || bus.sramA == AW'(BASE + SIZE + 1))) begin
                bad_hit = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic raise(input logic [24:0] a);
        tick();
        bus.ioctlA = a;
        bus.ioctlU = 1'b1;
    endtask

    task automatic drop();
        tick();
        bus.ioctlU = 1'b0;
        tick();
    endtask

    task automatic pulse_r();
        tick();
        bus.ioctlR = 1'b1;
        tick();
        bus.ioctlR = 1'b0;
    endtask

    // n counts cycles from the triggering cycle (n0 = cycles already elapsed)
    task automatic wait_valid(input int n0, output int n);
        bit seen = 1'b0;
        n = n0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            if (bus.ioctlV === 1'b1) seen = 1'b1;
            else n++;
        end
        check("valid_timeout", 32'(seen), 32'd1);
    endtask

    initial begin : stimulus
        int         n;
        logic [7:0] sum;

        reset      = 1'b1;
        bus.ioctlU = 1'b0;
        bus.ioctlR = 1'b0;
        bus.ioctlA = '0;
        foreach (mem[i]) mem[i] = 8'($urandom);

        // Reset values
        repeat (3) tick();
        @(negedge clock);
        check("rst_vidQ",   32'(bus.vidQ),   32'h00);
        check("rst_ioctlD", 32'(bus.ioctlD), 32'hFF);
        check("rst_ioctlV", 32'(bus.ioctlV), 32'h0);
        check("rst_sramA",  32'(bus.sramA),  32'h0);
        check("rst_sramOe", 32'(bus.sramOe), 32'h0);
        check("rst_csum",   32'(bus.csum),   32'h00);
        tick();
        reset = 1'b0;

        // First byte, no video
        mem[0] = 8'h3C;
        raise(25'd0);
        wait_valid(0, n);
        check("lat_first", 32'(n), 32'(WAIT + 2));
        check("byte_first", 32'(bus.ioctlD), 32'h3C);
        drop();
        @(negedge clock);
        check("fall_valid_off", 32'(bus.ioctlV), 32'h0);
        check("fall_data_held", 32'(bus.ioctlD), 32'h3C);

        // Stream 16 bytes with video slots stealing cycles
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        ce_mode = 1'b1;
        raise(25'd0);
        sum = 8'h00;
        for (int k = 0; k < 16; k++) begin
            wait_valid(0, n);
            check("stream_byte", 32'(bus.ioctlD), 32'(exp_byte(longint'(k))));
            pulse_r();
            sum = sum + exp_byte(longint'(k));
        end
        check("csum_stream", 32'(bus.csum), 32'(CSUM_ON ? sum : 8'h00));
        drop();
        ce_mode = 1'b0;
        repeat (4) tick();

        // SIZE boundary: last backed byte, then two fill bytes
        bad_hit   = 1'b0;
        watch_oor = 1'b1;
        raise(25'(SIZE - 1));
        wait_valid(0, n);
        check("lat_last", 32'(n), 32'(WAIT + 2));
        check("byte_last", 32'(bus.ioctlD), 32'(exp_byte(longint'(SIZE - 1))));
        pulse_r();
        wait_valid(1, n);
        check("lat_oor", 32'(n), 32'd2);
        check("byte_oor0", 32'(bus.ioctlD), 32'(exp_byte(longint'(SIZE))));
        pulse_r();
        wait_valid(1, n);
        check("byte_oor1", 32'(bus.ioctlD), 32'(exp_byte(longint'(SIZE + 1))));
        drop();
        watch_oor = 1'b0;
        check("oor_no_access", 32'(bad_hit), 32'h0);

        // Index wrap at 2^AW
        raise({4'hA, 21'h1FFFFF});
        wait_valid(0, n);
        check("lat_top", 32'(n), 32'd2);
        check("byte_top", 32'(bus.ioctlD), 32'(exp_byte(longint'(21'h1FFFFF))));
        pulse_r();
        wait_valid(1, n);
        check("lat_wrap", 32'(n), 32'(WAIT + 2));
        check("byte_wrap", 32'(bus.ioctlD), 32'(exp_byte(longint'(1) << AW)));
        check("csum_wrap", 32'(bus.csum), 32'(CSUM_ON ? 8'hFF : 8'h00));
        drop();

        // Checksum over F0,20,01 and simultaneous ioctlR / ioctlU fall
        mem[4] = 8'hF0;
        mem[5] = 8'h20;
        mem[6] = 8'h01;
        raise(25'd4);
        sum = 8'h00;
        for (int k = 4; k < 7; k++) begin
            wait_valid(0, n);
            if (k == 4) check("csum_cleared", 32'(bus.csum), 32'h00);
            check("csum_byte", 32'(bus.ioctlD), 32'(exp_byte(longint'(k))));
            pulse_r();
            sum = sum + exp_byte(longint'(k));
        end
        check("csum_value", 32'(bus.csum), 32'(CSUM_ON ? sum : 8'h00));
        wait_valid(1, n);
        tick();
        bus.ioctlR = 1'b1;
        bus.ioctlU = 1'b0;
        tick();
        bus.ioctlR = 1'b0;
        @(negedge clock);
        check("simul_valid_off", 32'(bus.ioctlV), 32'h0);
        check("simul_csum_held", 32'(bus.csum), 32'(CSUM_ON ? 8'h11 : 8'h00));

        // ioctlU falls while in SETUP
        raise(25'd2);
        tick();
        bus.ioctlU = 1'b0;
        @(negedge clock);
        check("setup_addr", 32'(bus.sramA), 32'(BASE + 2));
        tick();
        @(negedge clock);
        check("abort_valid_off", 32'(bus.ioctlV), 32'h0);
        check("abort_idle_addr", 32'(bus.sramA), 32'h0);

        // Reset while VALID, no restart without a fresh rise
        raise(25'd9);
        wait_valid(0, n);
        check("byte_9", 32'(bus.ioctlD), 32'(exp_byte(64'd9)));
        tick();
        reset = 1'b1;
        tick();
        @(negedge clock);
        check("rst_mid_valid", 32'(bus.ioctlV), 32'h0);
        check("rst_mid_data",  32'(bus.ioctlD), 32'hFF);
        check("rst_mid_csum",  32'(bus.csum),   32'h00);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        @(negedge clock);
        check("no_restart_valid", 32'(bus.ioctlV), 32'h0);
        check("no_restart_addr",  32'(bus.sramA),  32'h0);
        tick();
        bus.ioctlU = 1'b0;
        raise(25'd7);
        wait_valid(0, n);
        check("lat_restart", 32'(n), 32'(WAIT + 2));
        check("byte_7", 32'(bus.ioctlD), 32'(exp_byte(64'd7)));
        drop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
